traffic_display_scan: RTL and testbench
=======================================

// Module: traffic_display_scan
// PURPOSE
//  Consumer end of the countdown-time interface. Latches the four BCD digits
//  (A_Time_L/H, B_Time_L/H) from the light controller and drives a 4-digit
//  multiplexed seven-segment display. Handles blink for wink mode,
//  leading-zero blanking and invalid-BCD flagging.
// PARAMETERS
//  SCAN_DIV      1000  Clk cycles per digit slot (>=2); prescaler width = clog2(SCAN_DIV)
//  BLINK_FRAMES  64    full 4-digit frames per blink half-period (>=1)
// PORTS
//  Clk        in   1  system clock, all logic on rising edge
//  Rst        in   1  synchronous reset, active-high
//  Ena        in   1  display enable; 0 = blank display and hold all counters
//  Load       in   1  strobe: capture the four BCD inputs into shadow registers
//  A_Time_L   in   4  road A countdown, units digit (BCD)
//  A_Time_H   in   4  road A countdown, tens digit (BCD)
//  B_Time_L   in   4  road B countdown, units digit (BCD)
//  B_Time_H   in   4  road B countdown, tens digit (BCD)
//  Wink       in   1  blink request from controller wink mode
//  Clr_Err    in   1  clear sticky Bcd_Err
//  Seg        out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//  Dig        out  4  one-hot digit enable, registered; 0000 = all dark
//  Bcd_Err    out  1  sticky: a latched nibble was >9
// BEHAVIOUR
//  - Rst has priority over every input. Next edge: Seg=0, Dig=0, Bcd_Err=0,
//    shadow regs=0, slot idx=0, prescaler=0, frame cnt=0, blink phase=visible.
//  - Shadow: on Load=1, all four nibbles are captured together.
//    Seg/Dig are registered from the shadow regs: Load at edge n -> visible at n+2.
//    No partial or torn digit is ever displayed.
//  - Slot order: idx 0=A_L, 1=A_H, 2=B_L, 3=B_H. Dig = 1<<idx.
//  - Prescaler counts 0..SCAN_DIV-1. At the terminal value it wraps to 0 and
//    idx advances mod 4. The idx 3->0 wrap ends a frame.
//  - Frame cnt counts 0..BLINK_FRAMES-1. At frame end, if it is at the
//    terminal value, it wraps and the blink phase toggles.
//  - While Wink=0: blink phase is forced visible and frame cnt is held at 0.
//    On a Wink rise, the display starts in the visible phase.
//  - Dark blink phase with Wink=1: Dig=0000, Seg=0. Scan still runs.
//  - Ena=0: Dig=0000, Seg=0. Prescaler, idx, frame cnt and phase hold.
//    Load and Bcd_Err logic remain active. On Ena=1 the scan resumes at the
//    held idx.
//  - Decode 0..9 {g..a}:
//    0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//    5=1101101  6=1111101  7=0000111  8=1111111  9=1101111
//  - Nibble >9 displays "-" (Seg=1000000) in its slot.
//  - Leading-zero blanking: an H slot with nibble 0 gives Seg=0000000.
//    Dig stays asserted. L slots are never blanked.
//  - Bcd_Err is set the edge after a Load captures any nibble >9.
//    Clr_Err clears it. If set and clear coincide, set wins.
// TESTING  (SCAN_DIV=4, BLINK_FRAMES=2)
//  1 Rst, then Load A=2,5 B=0,7 with Ena=1 -> Dig 0001/0010/0100/1000 for
//    4 cycles each; Seg 1101101/1011011/0000111/0000000.
//  2 Wink=1 with digits as in 1 -> 32 cycles scanning, then 32 cycles Dig=0000
//    and Seg=0, repeating. Wink=0 mid-dark -> visible on the next edge.
//  3 Load A_L=4'hC -> slot 0 shows Seg=1000000 and Bcd_Err=1 next cycle.
//    Clr_Err together with another bad Load -> Bcd_Err stays 1.
//    Clr_Err alone -> 0.
//  4 Load new digits mid-slot -> Seg changes exactly 2 edges later.
//    No other slot is affected.
//  5 Rst mid-frame (idx=2) -> next edge Dig=0, Seg=0, Bcd_Err=0.
//    After release the scan restarts at idx 0 and shows 0 in L slots.
//  6 Ena=0 for 10 cycles at idx=1 -> Dig=0000 throughout.
//    On Ena=1, slot idx 1 resumes with the remaining prescaler count.

Source files
------------

// File: rtl/traffic_display_scan.sv
// Four-digit multiplexed seven-segment scanner for the countdown times coming from the
// light controller. It provides shadowed BCD capture, wink blinking, leading-zero
// blanking and a sticky flag for invalid BCD.
module traffic_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Ena,
  input  logic       Load,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       Wink,
  input  logic       Clr_Err,
  output logic [6:0] Seg,
  output logic [3:0] Dig,
  output logic       Bcd_Err
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]   pre;
  logic [1:0]      idx;
  logic [FW-1:0]   frm;
  logic            dark;
  logic [3:0][3:0] sh;      // slot-ordered: A_L, A_H, B_L, B_H
  logic            s1_vld;
  logic [1:0]      s1_idx;
  logic [3:0]      s1_nib;
  logic            bad_in, slot_end, frame_end, show;
  logic [6:0]      seg_nxt;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    bad_in    = (A_Time_L > 4'd9) || (A_Time_H > 4'd9) ||
                (B_Time_L > 4'd9) || (B_Time_H > 4'd9);
    slot_end  = (pre == PRE_LAST);
    frame_end = slot_end && (idx == 2'd3);
    // Ena and Wink gate the final stage directly, so both take effect on the very next edge
    show      = s1_vld && Ena && !(Wink && dark);
    seg_nxt   = (s1_idx[0] && (s1_nib == 4'd0)) ? 7'b0000000 : dec(s1_nib);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pre     <= '0;
      idx     <= '0;
      frm     <= '0;
      dark    <= 1'b0;
      sh      <= '0;
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_nib  <= '0;
      Seg     <= '0;
      Dig     <= '0;
      Bcd_Err <= 1'b0;
    end else begin
      if (Load) sh <= {B_Time_H, B_Time_L, A_Time_H, A_Time_L};

      if (Load && bad_in) Bcd_Err <= 1'b1;
      else if (Clr_Err)   Bcd_Err <= 1'b0;

      if (Ena) begin
        pre <= slot_end ? '0 : pre + 1'b1;
        if (slot_end) idx <= idx + 2'd1;
      end

      if (!Wink) begin
        frm  <= '0;
        dark <= 1'b0;
      end else if (Ena && frame_end) begin
        if (frm == FRM_LAST) begin
          frm  <= '0;
          dark <= ~dark;
        end else begin
          frm <= frm + 1'b1;
        end
      end

      // Stage 1 reads the whole nibble from the shadow, so a digit can never be shown torn
      s1_vld <= 1'b1;
      s1_idx <= idx;
      s1_nib <= sh[idx];

      Dig <= show ? (4'b0001 << s1_idx) : 4'b0000;
      Seg <= show ? seg_nxt : 7'b0000000;
    end
  end

endmodule

// File: tb/tb_traffic_display_scan.sv
// Directed bench for traffic_display_scan (SCAN_DIV=4, BLINK_FRAMES=2). Each check is
// tied to an absolute cycle number counted from the reset edge.
module tb_traffic_display_scan;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Ena = 1'b1;
  logic       Load = 1'b0;
  logic [3:0] A_Time_L = '0, A_Time_H = '0, B_Time_L = '0, B_Time_H = '0;
  logic       Wink = 1'b0;
  logic       Clr_Err = 1'b0;
  logic [6:0] Seg;
  logic [3:0] Dig;
  logic       Bcd_Err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  traffic_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .Clk(Clk), .Rst(Rst), .Ena(Ena), .Load(Load),
    .A_Time_L(A_Time_L), .A_Time_H(A_Time_H),
    .B_Time_L(B_Time_L), .B_Time_H(B_Time_H),
    .Wink(Wink), .Clr_Err(Clr_Err),
    .Seg(Seg), .Dig(Dig), .Bcd_Err(Bcd_Err)
  );

  always #5 Clk = ~Clk;

  // digits A_L=5 A_H=2 B_L=7 B_H=0 (H=0 blanks)
  logic [6:0] seg_ab [4] = '{7'b1101101, 7'b1011011, 7'b0000111, 7'b0000000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) tick();
  endtask

  task automatic set_bcd(input logic [3:0] al, input logic [3:0] ah,
                         input logic [3:0] bl, input logic [3:0] bh);
    A_Time_L = al; A_Time_H = ah; B_Time_L = bl; B_Time_H = bh;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int slot;
    logic [3:0] edig;
    logic [6:0] eseg;

    // reset state
    Rst = 1'b1;
    tick(); tick();
    cyc = 0;
    chk("rst_dig", Dig, 4'b0000);
    chk("rst_seg", Seg, 7'b0000000);
    chk("rst_err", Bcd_Err, 1'b0);

    // 1: basic scan, 4 cycles per slot; load lands two edges later
    Rst = 1'b0;
    set_bcd(4'd5, 4'd2, 4'd7, 4'd0);
    Load = 1'b1;
    tick();                                   // cyc 1: load captured
    Load = 1'b0;
    chk("fill_dig", Dig, 4'b0000);
    tick();                                   // cyc 2: first slot, old shadow (0)
    chk("scan_dig2", Dig, 4'b0001);
    chk("scan_seg2_old", Seg, 7'b0111111);
    for (int k = 3; k <= 17; k++) begin
      tick();
      slot = ((k - 2) / 4) % 4;
      chk("scan_dig", Dig, 4'b0001 << slot);
      chk("scan_seg", Seg, seg_ab[slot]);
    end

    // 2: wink; dark windows come out as cycles 49..80 and 113..
    Wink = 1'b1;
    for (int k = 18; k <= 120; k++) begin
      tick();
      slot = ((k - 2) / 4) % 4;
      if ((k >= 49 && k <= 80) || k >= 113) begin
        edig = 4'b0000; eseg = 7'b0000000;
      end else begin
        edig = 4'b0001 << slot; eseg = seg_ab[slot];
      end
      chk("wink_dig", Dig, edig);
      chk("wink_seg", Seg, eseg);
    end
    Wink = 1'b0;
    tick();                                   // cyc 121: visible at once
    chk("wink_off_dig", Dig, 4'b0010);
    chk("wink_off_seg", Seg, 7'b1011011);

    // 3: invalid BCD, sticky error, set beats clear
    set_bcd(4'hC, 4'd2, 4'd7, 4'd0);
    Load = 1'b1;
    tick();                                   // cyc 122
    Load = 1'b0;
    chk("err_set", Bcd_Err, 1'b1);
    goto(130);
    chk("dash_dig", Dig, 4'b0001);
    chk("dash_seg", Seg, 7'b1000000);
    Clr_Err = 1'b1; Load = 1'b1;
    tick();                                   // cyc 131
    Load = 1'b0;
    chk("err_set_wins", Bcd_Err, 1'b1);
    tick();                                   // cyc 132
    Clr_Err = 1'b0;
    chk("err_clr", Bcd_Err, 1'b0);

    // 4: mid-slot load on slot 1 (cycles 134..137)
    goto(134);
    set_bcd(4'd5, 4'd9, 4'd7, 4'd0);
    Load = 1'b1;
    tick();                                   // cyc 135: captured
    Load = 1'b0;
    chk("ml_dig135", Dig, 4'b0010);
    chk("ml_seg135", Seg, 7'b1011011);
    tick();
    chk("ml_seg136", Seg, 7'b1011011);
    chk("ml_err136", Bcd_Err, 1'b0);
    tick();
    chk("ml_seg137", Seg, 7'b1101111);
    goto(138);
    chk("ml_dig138", Dig, 4'b0100);
    chk("ml_seg138", Seg, 7'b0000111);
    goto(142);
    chk("ml_dig142", Dig, 4'b1000);
    chk("ml_seg142", Seg, 7'b0000000);
    goto(146);
    chk("ml_dig146", Dig, 4'b0001);
    chk("ml_seg146", Seg, 7'b1101101);

    // 5: reset mid-frame at idx 2; a bad Load under reset is ignored
    goto(149);
    set_bcd(4'hF, 4'd9, 4'd7, 4'd0);
    Load = 1'b1;
    tick();                                   // cyc 150
    Load = 1'b0;
    chk("err_pre_rst", Bcd_Err, 1'b1);
    goto(153);
    chk("pre_rst_dig", Dig, 4'b0010);
    Rst = 1'b1; Load = 1'b1;
    tick();                                   // cyc 154: reset edge
    Rst = 1'b0; Load = 1'b0;
    chk("mid_rst_dig", Dig, 4'b0000);
    chk("mid_rst_seg", Seg, 7'b0000000);
    chk("mid_rst_err", Bcd_Err, 1'b0);
    tick();
    chk("rst_fill_dig", Dig, 4'b0000);
    goto(156);
    chk("rst_s0_dig", Dig, 4'b0001);
    chk("rst_s0_seg", Seg, 7'b0111111);
    goto(160);
    chk("rst_s1_dig", Dig, 4'b0010);
    chk("rst_s1_seg", Seg, 7'b0000000);
    goto(164);
    chk("rst_s2_dig", Dig, 4'b0100);
    chk("rst_s2_seg", Seg, 7'b0111111);

    // 6: Ena low for 10 edges while idx=1, pre=1; load still works
    goto(175);
    Ena = 1'b0;
    tick();                                   // cyc 176
    chk("ena_off_dig", Dig, 4'b0000);
    chk("ena_off_seg", Seg, 7'b0000000);
    goto(179);
    set_bcd(4'hC, 4'd0, 4'd3, 4'd0);
    Load = 1'b1;
    tick();                                   // cyc 180
    Load = 1'b0;
    chk("ena_off_err", Bcd_Err, 1'b1);
    chk("ena_off_dig180", Dig, 4'b0000);
    goto(185);
    chk("ena_off_dig185", Dig, 4'b0000);
    Ena = 1'b1;
    tick();                                   // cyc 186
    chk("resume_dig", Dig, 4'b0010);
    chk("resume_seg", Seg, 7'b0000000);
    goto(189);
    chk("resume_dig189", Dig, 4'b0010);
    tick();                                   // cyc 190
    chk("resume_dig190", Dig, 4'b0100);
    chk("resume_seg190", Seg, 7'b1001111);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
